dec38_seq: RTL and testbench
============================

// Module: dec38_seq
// PURPOSE
//  Buffered, timed 3-to-8 decoder: accepts 3-bit codes over a valid/ready
//  handshake, queues them, and shows each as a one-hot 8-bit LED pattern for a
//  fixed hold time followed by a blank gap. Pairs with the 8-to-3 priority
//  encoder: encoder output code -> this block -> LED bar / 7-seg on the board.
// PARAMETERS
//  DEPTH        4   FIFO entries; power of 2, >=2
//  HOLD_CYCLES  8   cycles each code is shown; >=1
//  GAP_CYCLES   2   blank cycles after each code; >=0 (0 = back-to-back)
// PORTS
//  clk       in   1   single clock, all state on posedge
//  rst_n     in   1   asynchronous, active-low reset
//  en        in   1   1: display FSM runs; 0: FSM and timers frozen
//  in_valid  in   1   in_code valid this cycle
//  in_code   in   3   code to decode (0..7)
//  in_ready  out  1   FIFO not full; accept = in_valid & in_ready
//  out       out  8   registered one-hot pattern, 1<<code while SHOW, else 0
//  h         out  7   active-low 7-seg of the shown code (see CONFIGURATION)
//  busy      out  1   state != IDLE or FIFO non-empty
//  count     out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, count=0, FIFO pointers=0, timer=0,
//   out=8'h00, h=7'b1111111, busy=0; in_ready=1 (combinational from count);
//   writes during reset are discarded.
//  in_ready = (count != DEPTH). Push blocked when full even if a pop occurs in
//   the same cycle. Push+pop same cycle (not full, not empty): count unchanged.
//  FIFO accepts regardless of en. Pop only when en=1.
//  FSM states IDLE, SHOW, GAP (registered; timer counts down to 0):
//   IDLE: en & count!=0 -> pop head into cur_code, timer=HOLD_CYCLES-1, ->SHOW.
//   SHOW: out=1<<cur_code. timer!=0 -> timer-1. timer==0:
//    GAP_CYCLES>0 -> timer=GAP_CYCLES-1, ->GAP;
//    GAP_CYCLES==0 & count!=0 -> pop, reload, stay SHOW (no blank cycle);
//    else ->IDLE.
//   GAP: out=0. timer!=0 -> timer-1. timer==0: count!=0 -> pop, ->SHOW; else IDLE.
//  Latency: push at edge t into empty FIFO in IDLE -> pop at edge t+1 -> out
//   valid from edge t+2, exactly HOLD_CYCLES cycles; then GAP_CYCLES zeros.
//  en=0: state, timer, out, h held unchanged; en=1 resumes where frozen.
//  out is always 0 or exactly one bit set; never more than one.
//  Codes emerge in push order; FIFO pointers wrap modulo DEPTH.
//  Mid-operation reset: everything returns to reset values immediately;
//   queued codes are lost.
// CONFIGURATION
//  DEC38_SEG_EN defined: h registered alongside out; in SHOW h = digit of
//   cur_code: 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100
//   6:0100000 7:0001111; in IDLE/GAP h=7'b1111111 (blank).
//  Not defined: h tied to 7'b1111111, no segment logic synthesised.
// STRUCTURE
//  dec38_pkg: state encodings (IDLE=2'd0, SHOW=2'd1, GAP=2'd2), SEG_BLANK,
//   8-entry SEG_DIGIT table for codes 0..7.
//  Sub-module dec38_fifo (DEPTH x 3 bits; push/pop/full/empty/count).
//  Top: FSM + timer + one-hot/segment output registers.
// TESTING
//  1 Reset: rst_n=0 mid-SHOW -> out=00, h=1111111, busy=0, count=0 at once.
//  2 Single: push 3'd5, HOLD=8, GAP=2 -> out=8'h20 for 8 cycles from t+2,
//    then 8'h00 for 2 cycles, busy drops; h=0100100 while shown (SEG_EN).
//  3 Fill: push 0,1,2,3,4 back-to-back with en=0 -> count=4, in_ready=0,
//    code 4 refused; en=1 -> 01,02,04,08 shown in order, separated by gaps.
//  4 GAP_CYCLES=0: push 7 then 0 -> out 80 for 8 cycles then 01 next cycle,
//    no zero cycle between.
//  5 Freeze: drop en for 5 cycles during SHOW of code 2 -> out stays 8'h04,
//    total shown cycles = 8 + 5.
//  6 Wrap/simultaneous: stream 12 random codes with push+pop overlap ->
//    output order matches input order, out always one-hot or zero.

Source files
------------

// File: rtl/dec38_pkg.sv
// -----------------------------------------------------------------------------
// dec38_pkg
// Shared definitions for the buffered, timed 3-to-8 decoder (dec38_seq):
//   - display FSM state encodings (legacy-compatible localparam constants)
//   - active-low 7-segment patterns: blank and digits 0..7
//   - one-hot helper used by the LED output register
// Segment bit order is {a,b,c,d,e,f,g}; a 0 lights the segment.
// -----------------------------------------------------------------------------
package dec38_pkg;

  // Display FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit patterns indexed by code; element 0 is the rightmost entry.
  localparam logic [7:0][6:0] SEG_DIGIT = {
    7'b0001111,   // 7
    7'b0100000,   // 6
    7'b0100100,   // 5
    7'b1001100,   // 4
    7'b0000110,   // 3
    7'b0010010,   // 2
    7'b1001111,   // 1
    7'b0000001    // 0
  };

  // 3-bit code to one-hot LED pattern.
  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'd1 << code;
  endfunction

endpackage : dec38_pkg

// File: rtl/dec38_fifo.sv
// -----------------------------------------------------------------------------
// dec38_fifo
// Small synchronous FIFO holding 3-bit codes for dec38_seq.
// Parameters:
//   DEPTH  number of entries; power of 2, >= 2 (pointers wrap naturally)
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset (pointers and occupancy cleared)
//   push   write request; ignored while full
//   pop    read request; ignored while empty
//   din    code to write
//   head   code at the read pointer (valid when !empty)
//   full   occupancy == DEPTH
//   empty  occupancy == 0
//   count  occupancy 0..DEPTH
// A push is refused when full even if a pop happens in the same cycle, so
// full/in_ready depend only on registered state.
// -----------------------------------------------------------------------------
module dec38_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [2:0]             din,
  output logic [2:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after being written, and reset clears the pointers/occupancy that
  // decide what is readable, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule : dec38_fifo

// File: rtl/dec38_seq.sv
// -----------------------------------------------------------------------------
// dec38_seq
// Buffered, timed 3-to-8 decoder. Codes arrive over a valid/ready handshake,
// are queued in dec38_fifo, and each is shown as a one-hot LED pattern for
// HOLD_CYCLES cycles followed by GAP_CYCLES blank cycles.
// Parameters:
//   DEPTH        FIFO entries; power of 2, >= 2
//   HOLD_CYCLES  cycles each code is shown; >= 1
//   GAP_CYCLES   blank cycles after each code; >= 0 (0 = back-to-back)
// Ports:
//   clk       clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   en        1: display FSM runs; 0: FSM, timer and outputs frozen
//   in_valid  in_code valid this cycle
//   in_code   code to decode (0..7)
//   in_ready  FIFO not full; accept = in_valid & in_ready
//   out       registered one-hot pattern while showing, else 0
//   h         active-low 7-segment digit of the shown code
//   busy      FSM not idle or FIFO non-empty
//   count     FIFO occupancy 0..DEPTH
// Build option:
//   DEC38_SEG_EN  when defined, h is a register tracking out (digit while
//                 showing, blank otherwise); when undefined, h is tied blank
//                 and no segment logic exists.
// Timing: out/h are registered from the current state, so they trail the
// FSM by one cycle: a pop at edge t+1 shows its code from edge t+2.
// -----------------------------------------------------------------------------
module dec38_seq #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [2:0]             in_code,
  output logic                   in_ready,
  output logic [7:0]             out,
  output logic [6:0]             h,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  import dec38_pkg::*;

  // Timer must hold the larger of the two reload values.
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [2:0]    cur_code;
  logic [2:0]    cur_nxt;
  logic          pop;
  logic [2:0]    head;
  logic          full;
  logic          empty;

  // ---------------------------------------------------------------------------
  // Code queue. Accepts regardless of en; the FIFO itself refuses when full.
  // ---------------------------------------------------------------------------
  dec38_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_code),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign in_ready = ~full;
  assign busy     = (state != ST_IDLE) | ~empty;

  // ---------------------------------------------------------------------------
  // Display FSM next-state. Nothing advances (and nothing pops) while en=0.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cur_nxt   = cur_code;
    pop       = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            cur_nxt   = head;
            timer_nxt = HOLD_LOAD;
            state_nxt = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (timer != '0) begin
            timer_nxt = timer - TW'(1);
          end else if (GAP_CYCLES > 0) begin
            timer_nxt = GAP_LOAD;
            state_nxt = ST_GAP;
          end else if (!empty) begin
            // Back-to-back mode: reload with the next code, no blank cycle.
            pop       = 1'b1;
            cur_nxt   = head;
            timer_nxt = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (timer != '0) begin
            timer_nxt = timer - TW'(1);
          end else if (!empty) begin
            pop       = 1'b1;
            cur_nxt   = head;
            timer_nxt = HOLD_LOAD;
            state_nxt = ST_SHOW;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and LED register. out is decoded from the pre-edge state and
  // code, which is what keeps it one-hot or zero at all times.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      cur_code <= '0;
      out      <= 8'h00;
    end else if (en) begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      cur_code <= cur_nxt;
      out      <= (state == ST_SHOW) ? onehot8(cur_code) : 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional 7-segment register, aligned cycle-for-cycle with out.
  // ---------------------------------------------------------------------------
`ifdef DEC38_SEG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= SEG_BLANK;
    end else if (en) begin
      h <= (state == ST_SHOW) ? SEG_DIGIT[cur_code] : SEG_BLANK;
    end
  end
`else
  assign h = SEG_BLANK;
`endif

endmodule : dec38_seq

// File: tb/tb_dec38_seq.sv
// -----------------------------------------------------------------------------
// tb_dec38_seq
// Directed self-checking bench for dec38_seq. Two instances:
//   dut_a  DEPTH=4, HOLD=8, GAP=2
//   dut_b  DEPTH=4, HOLD=8, GAP=0 (back-to-back display)
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dec38_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en_a = 1'b1, vld_a = 1'b0;
  logic [2:0] code_a = 3'd0;
  logic       ready_a, busy_a;
  logic [7:0] out_a;
  logic [6:0] h_a;
  logic [2:0] cnt_a;

  logic       en_b = 1'b1, vld_b = 1'b0;
  logic [2:0] code_b = 3'd0;
  logic       ready_b, busy_b;
  logic [7:0] out_b;
  logic [6:0] h_b;
  logic [2:0] cnt_b;

  int tests = 0;
  int fails = 0;

  // Run-length capture of an output stream (leading zeros skipped).
  logic [7:0] run_val [$];
  int         run_len [$];
  int         bad_onehot;

  always #5 clk = ~clk;

  dec38_seq #(.DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(vld_a), .in_code(code_a),
    .in_ready(ready_a), .out(out_a), .h(h_a), .busy(busy_a), .count(cnt_a)
  );

  dec38_seq #(.DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(vld_b), .in_code(code_b),
    .in_ready(ready_b), .out(out_b), .h(h_b), .busy(busy_b), .count(cnt_b)
  );

  // Expected segment pattern for a shown code.
  function automatic logic [6:0] seg_exp(input logic [2:0] c);
`ifdef DEC38_SEG_EN
    case (c)
      3'd0:    return 7'b0000001;
      3'd1:    return 7'b1001111;
      3'd2:    return 7'b0010010;
      3'd3:    return 7'b0000110;
      3'd4:    return 7'b1001100;
      3'd5:    return 7'b0100100;
      3'd6:    return 7'b0100000;
      default: return 7'b0001111;
    endcase
`else
    return 7'b1111111;
`endif
  endfunction

  // One handshake beat; returns at the falling edge after the accepting edge.
  task automatic push(input bit b, input logic [2:0] c);
    if (b) begin vld_b = 1'b1; code_b = c; end
    else   begin vld_a = 1'b1; code_a = c; end
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask

  task automatic capture(input bit b, input int cycles);
    logic [7:0] v;
    bit started;
    started = 1'b0;
    bad_onehot = 0;
    run_val.delete();
    run_len.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      v = b ? out_b : out_a;
      if ((v & (v - 8'd1)) != 8'd0) bad_onehot++;
      if (!started && v == 8'h00) continue;
      started = 1'b1;
      if (run_val.size() != 0 && run_val[run_val.size()-1] == v)
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      else begin
        run_val.push_back(v);
        run_len.push_back(1);
      end
    end
  endtask

  task automatic test_reset;
    vld_a = 1'b1; code_a = 3'd3;        // offered during reset: must be dropped
    repeat (3) @(negedge clk);
    tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL reset_out: got %h expected 00", out_a); end
    tests++; if (h_a !== 7'b1111111) begin fails++; $display("FAIL reset_h: got %b expected 1111111", h_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
    vld_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (cnt_a !== 3'd0) begin fails++; $display("FAIL reset_write_dropped: count %0d expected 0", cnt_a); end
  endtask

  task automatic test_single;
    push(1'b0, 3'd5);
    tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL single_t0: got %h expected 00", out_a); end
    @(negedge clk);
    tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL single_t1: got %h expected 00", out_a); end
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy_a); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (out_a !== 8'h20) begin fails++; $display("FAIL single_show[%0d]: got %h expected 20", i, out_a); end
      tests++; if (h_a !== seg_exp(3'd5)) begin fails++; $display("FAIL single_h[%0d]: got %b expected %b", i, h_a, seg_exp(3'd5)); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL single_gap[%0d]: got %h expected 00", i, out_a); end
      tests++; if (h_a !== 7'b1111111) begin fails++; $display("FAIL single_gap_h[%0d]: got %b expected 1111111", i, h_a); end
    end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_idle: busy %b expected 0", busy_a); end
  endtask

  task automatic test_fill;
    logic [7:0] exp_v [7] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08};
    int         exp_l [7] = '{8, 2, 8, 2, 8, 2, 8};
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 3'(i));
    tests++; if (cnt_a !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", cnt_a); end
    tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b expected 0", ready_a); end
    push(1'b0, 3'd4);
    tests++; if (cnt_a !== 3'd4) begin fails++; $display("FAIL fill_refused: count %0d expected 4", cnt_a); end
    tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL fill_frozen: got %h expected 00", out_a); end
    en_a = 1'b1;
    capture(1'b0, 60);
    tests++;
    if (run_val.size() < 8) begin
      fails++; $display("FAIL fill_runs: got %0d runs expected at least 8", run_val.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests++; if (run_val[i] !== exp_v[i]) begin fails++; $display("FAIL fill_val[%0d]: got %h expected %h", i, run_val[i], exp_v[i]); end
        tests++; if (run_len[i] != exp_l[i]) begin fails++; $display("FAIL fill_len[%0d]: got %0d expected %0d", i, run_len[i], exp_l[i]); end
      end
      tests++; if (run_val[7] !== 8'h00) begin fails++; $display("FAIL fill_tail: got %h expected 00", run_val[7]); end
    end
    tests++; if (bad_onehot != 0) begin fails++; $display("FAIL fill_onehot: %0d bad samples expected 0", bad_onehot); end
  endtask

  task automatic test_freeze;
    int shown;
    shown = 0;
    push(1'b0, 3'd2);
    for (int i = 0; i < 30; i++) begin
      en_a = (i < 4 || i >= 9);
      @(negedge clk);
      if (out_a == 8'h04) shown++;
      if (i >= 4 && i < 9) begin
        tests++; if (out_a !== 8'h04) begin fails++; $display("FAIL freeze_hold[%0d]: got %h expected 04", i, out_a); end
      end
    end
    en_a = 1'b1;
    tests++; if (shown != 13) begin fails++; $display("FAIL freeze_total: got %0d cycles expected 13", shown); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL freeze_idle: busy %b expected 0", busy_a); end
  endtask

  task automatic test_gap0;
    push(1'b1, 3'd7);
    push(1'b1, 3'd0);
    capture(1'b1, 40);
    tests++;
    if (run_val.size() < 3) begin
      fails++; $display("FAIL gap0_runs: got %0d runs expected at least 3", run_val.size());
    end else begin
      tests++; if (run_val[0] !== 8'h80) begin fails++; $display("FAIL gap0_v0: got %h expected 80", run_val[0]); end
      tests++; if (run_len[0] != 8) begin fails++; $display("FAIL gap0_l0: got %0d expected 8", run_len[0]); end
      tests++; if (run_val[1] !== 8'h01) begin fails++; $display("FAIL gap0_v1: got %h expected 01", run_val[1]); end
      tests++; if (run_len[1] != 8) begin fails++; $display("FAIL gap0_l1: got %0d expected 8", run_len[1]); end
      tests++; if (run_val[2] !== 8'h00) begin fails++; $display("FAIL gap0_tail: got %h expected 00", run_val[2]); end
    end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL gap0_idle: busy %b expected 0", busy_b); end
  endtask

  task automatic test_stream;
    logic [2:0] codes [12] = '{3'd3, 3'd6, 3'd1, 3'd7, 3'd0, 3'd5, 3'd2, 3'd4, 3'd6, 3'd3, 3'd1, 3'd5};
    logic [2:0] got [$];
    logic [7:0] prev, v;
    int idx, pbudget, cyc, bad;
    bit acc;
    idx = 0; pbudget = 0; cyc = 0; bad = 0; prev = 8'h00;
    fork
      begin
        while (idx < 12 && pbudget < 600) begin
          vld_a = 1'b1; code_a = codes[idx];
          acc = ready_a;
          @(negedge clk);
          pbudget++;
          if (acc) idx++;
        end
        vld_a = 1'b0;
      end
      begin
        while (got.size() < 12 && cyc < 600) begin
          @(negedge clk);
          cyc++;
          v = out_a;
          if ((v & (v - 8'd1)) != 8'd0) bad++;
          if (v != 8'h00 && v != prev)
            for (int k = 0; k < 8; k++) if (v[k]) got.push_back(3'(k));
          prev = v;
        end
      end
    join
    tests++; if (idx != 12) begin fails++; $display("FAIL stream_pushed: got %0d expected 12", idx); end
    tests++; if (got.size() != 12) begin fails++; $display("FAIL stream_count: got %0d expected 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) begin
        tests++; if (got[i] !== codes[i]) begin fails++; $display("FAIL stream_order[%0d]: got %0d expected %0d", i, got[i], codes[i]); end
      end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL stream_onehot: %0d bad samples expected 0", bad); end
    repeat (15) @(negedge clk);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL stream_idle: busy %b expected 0", busy_a); end
  endtask

  task automatic test_reset_mid;
    push(1'b0, 3'd4);
    push(1'b0, 3'd6);
    repeat (4) @(negedge clk);
    tests++; if (out_a !== 8'h10) begin fails++; $display("FAIL mid_pre_show: got %h expected 10", out_a); end
    rst_n = 1'b0;
    #1;
    tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL mid_out: got %h expected 00", out_a); end
    tests++; if (h_a !== 7'b1111111) begin fails++; $display("FAIL mid_h: got %b expected 1111111", h_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", busy_a); end
    tests++; if (cnt_a !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d expected 0", cnt_a); end
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b expected 1", ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (out_a !== 8'h00) begin fails++; $display("FAIL mid_lost_out: got %h expected 00", out_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_lost_busy: got %b expected 0", busy_a); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_freeze();
    test_gap0();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dec38_seq
